// File: rtl/obj_pkg.sv
// Shared sprite-object definitions used by the RAM loader and the display-side readout path.
package obj_pkg;

  localparam int OBJ_W   = 32;
  localparam int OBJ_H   = 32;
  localparam int NUM_OBJ = 4;
  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INDEX = 3'd1,
    ST_PIX_A = 3'd2,
    ST_PIX_B = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_e;

  typedef logic [11:0] color_t;

  // Index 0 means "no object", so only 1..NUM_OBJ may be loaded.
  function automatic logic index_ok(input logic [7:0] b);
    return (b >= 8'd1) && (b <= 8'(NUM_OBJ));
  endfunction

endpackage

// File: rtl/obj_pixel_addr_ctr.sv
// Row-major pixel address counter for one sprite: col steps fastest, wraps at the sprite bounds.
module obj_pixel_addr_ctr
  import obj_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       step,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       last
);

  localparam logic [9:0] COL_LAST = 10'(OBJ_W - 1);
  localparam logic [9:0] ROW_LAST = 10'(OBJ_H - 1);

  logic [9:0] row_r;
  logic [9:0] col_r;

  // Advance col, carrying into row at the right edge of the sprite.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_r <= 10'd0;
      col_r <= 10'd0;
    end else if (clr) begin
      row_r <= 10'd0;
      col_r <= 10'd0;
    end else if (step) begin
      if (col_r == COL_LAST) begin
        col_r <= 10'd0;
        row_r <= (row_r == ROW_LAST) ? 10'd0 : row_r + 10'd1;
      end else begin
        col_r <= col_r + 10'd1;
        row_r <= row_r;
      end
    end else begin
      row_r <= row_r;
      col_r <= col_r;
    end
  end

  assign row  = row_r;
  assign col  = col_r;
  assign last = (col_r == COL_LAST) && (row_r == ROW_LAST);

endmodule

// File: rtl/object_ram_loader.sv
// Parses HDR/index/pixel-pair packets from a byte stream and issues one sprite RAM write per pixel.
module object_ram_loader
  import obj_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [2:0]  wr_index,
  output logic [9:0]  wr_row,
  output logic [9:0]  wr_col,
  output logic [11:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  loader_state_e state_r;
  logic [2:0]    index_r;
  logic [3:0]    r_nib_r;
  logic          wr_en_r;
  logic [2:0]    wr_index_r;
  logic [9:0]    wr_row_r;
  logic [9:0]    wr_col_r;
  color_t        wr_data_r;
  logic          done_r;
  logic          err_r;

  logic          accept_s;
  logic          ctr_clr_s;
  logic          ctr_step_s;
  logic [9:0]    row_s;
  logic [9:0]    col_s;
  logic          last_s;

  assign in_ready   = (state_r != ST_DONE);
  assign accept_s   = in_valid && in_ready;
  assign ctr_clr_s  = (state_r == ST_INDEX) && accept_s && index_ok(in_data);
  assign ctr_step_s = (state_r == ST_PIX_B) && accept_s;

  obj_pixel_addr_ctr u_addr_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr_s),
    .step  (ctr_step_s),
    .row   (row_s),
    .col   (col_s),
    .last  (last_s)
  );

  // Packet FSM; write/done/err are single-cycle pulses, write fields hold until the next write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      index_r    <= 3'd0;
      r_nib_r    <= 4'd0;
      wr_en_r    <= 1'b0;
      wr_index_r <= 3'd0;
      wr_row_r   <= 10'd0;
      wr_col_r   <= 10'd0;
      wr_data_r  <= 12'd0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && (in_data == HDR)) begin
            state_r <= ST_INDEX;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_INDEX: begin
          if (accept_s) begin
            if (index_ok(in_data)) begin
              index_r <= in_data[2:0];
              state_r <= ST_PIX_A;
            end else begin
              err_r   <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_INDEX;
          end
        end
        ST_PIX_A: begin
          if (accept_s) begin
            r_nib_r <= in_data[3:0];
            state_r <= ST_PIX_B;
          end else begin
            state_r <= ST_PIX_A;
          end
        end
        ST_PIX_B: begin
          if (accept_s) begin
            wr_en_r    <= 1'b1;
            wr_index_r <= index_r;
            wr_row_r   <= row_s;
            wr_col_r   <= col_s;
            wr_data_r  <= {r_nib_r, in_data};
            if (last_s) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_PIX_A;
            end
          end else begin
            state_r <= ST_PIX_B;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_en    = wr_en_r;
  assign wr_index = wr_index_r;
  assign wr_row   = wr_row_r;
  assign wr_col   = wr_col_r;
  assign wr_data  = wr_data_r;
  assign busy     = (state_r != ST_IDLE);
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_object_ram_loader.sv
// Scoreboard bench for object_ram_loader: expected writes are queued as pixel bytes are accepted.
module tb_object_ram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [2:0]  wr_index;
  logic [9:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [2:0]  idx;
    logic [9:0]  row;
    logic [9:0]  col;
    logic [11:0] data;
    logic        last;
  } wr_item_t;

  wr_item_t exp_q[$];
  wr_item_t mon_item;
  logic     mon_exp_done;
  int errors  = 0;
  int checks  = 0;
  int n_writes = 0;
  int n_done  = 0;
  int gap_pct = 0;

  object_ram_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write monitor: pops the scoreboard on every wr_en, checks done alignment.
  always @(negedge clk) begin
    mon_exp_done = 1'b0;
    if (wr_en === 1'b1) begin
      n_writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got idx=%0d row=%0d col=%0d data=%h, expected no write",
                 wr_index, wr_row, wr_col, wr_data);
      end else begin
        mon_item = exp_q.pop_front();
        mon_exp_done = mon_item.last;
        if ({wr_index, wr_row, wr_col, wr_data} !== {mon_item.idx, mon_item.row, mon_item.col, mon_item.data}) begin
          errors++;
          $display("FAIL write: got idx=%0d row=%0d col=%0d data=%h, expected idx=%0d row=%0d col=%0d data=%h",
                   wr_index, wr_row, wr_col, wr_data, mon_item.idx, mon_item.row, mon_item.col, mon_item.data);
        end
      end
    end
    if (wr_en === 1'b1 || done === 1'b1) begin
      checks++;
      if (done !== mon_exp_done) begin
        errors++;
        $display("FAIL done_align: got done=%b, expected %b", done, mon_exp_done);
      end
    end
    if (done === 1'b1) begin
      n_done++;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_done: got in_ready=%b, expected 0", in_ready);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        acc      = (in_ready === 1'b1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    if (!acc) begin
      errors++;
      checks++;
      $display("FAIL byte_accept: byte %h not accepted within 64 cycles", b);
    end
  endtask

  // mode 0: 0F/AB, 1: random, 2: row/col pattern, 3: A5/A5 first then random
  task automatic send_packet(input logic [7:0] idx, input int mode, input int npix);
    logic [7:0] a;
    logic [7:0] b;
    send_byte(8'hA5);
    send_byte(idx);
    for (int p = 0; p < npix; p++) begin
      case (mode)
        0: begin a = 8'h0F; b = 8'hAB; end
        1: begin a = 8'($urandom); b = 8'($urandom); end
        2: begin a = 8'(p / 32); b = 8'((p % 32) * 7); end
        default: begin
          if (p == 0) begin a = 8'hA5; b = 8'hA5; end
          else begin a = 8'($urandom); b = 8'($urandom); end
        end
      endcase
      send_byte(a);
      send_byte(b);
      exp_q.push_back('{idx: idx[2:0], row: 10'(p / 32), col: 10'(p % 32),
                        data: {a[3:0], b}, last: (p == 1023)});
    end
  endtask

  task automatic drain_and_check(input string name, input int w0, input int d0, input int nw, input int nd);
    repeat (3) @(negedge clk);
    checks++;
    if (n_writes - w0 !== nw) begin
      errors++;
      $display("FAIL %s_writes: got %0d, expected %0d", name, n_writes - w0, nw);
    end
    checks++;
    if (n_done - d0 !== nd) begin
      errors++;
      $display("FAIL %s_done: got %0d, expected %0d", name, n_done - d0, nd);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_queue: got %0d pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, wr_en, busy, done, err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got ready/wr_en/busy/done/err=%b, expected 10000",
               {in_ready, wr_en, busy, done, err});
    end
    checks++;
    if ({wr_index, wr_row, wr_col, wr_data} !== 35'd0) begin
      errors++;
      $display("FAIL reset_fields: got idx=%0d row=%0d col=%0d data=%h, expected all 0",
               wr_index, wr_row, wr_col, wr_data);
    end
  endtask

  task automatic test_full_packet();
    int w0 = n_writes;
    int d0 = n_done;
    send_byte(8'hA5);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_hdr: got %b, expected 1", busy);
    end
    send_byte(8'h02);
    for (int p = 0; p < 1024; p++) begin
      send_byte(8'h0F);
      send_byte(8'hAB);
      exp_q.push_back('{idx: 3'd2, row: 10'(p / 32), col: 10'(p % 32), data: 12'hFAB, last: (p == 1023)});
    end
    drain_and_check("full", w0, d0, 1024, 1);
  endtask

  task automatic test_garbage();
    int w0 = n_writes;
    int d0 = n_done;
    logic [7:0] junk [3];
    junk[0] = 8'h00; junk[1] = 8'hFF; junk[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      send_byte(junk[i]);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL garbage_busy: byte %h got busy=%b, expected 0", junk[i], busy);
      end
    end
    send_packet(8'h01, 1, 1024);
    drain_and_check("garbage", w0, d0, 1024, 1);
  endtask

  task automatic test_bad_index();
    int w0 = n_writes;
    int d0 = n_done;
    logic [7:0] bad [2];
    bad[0] = 8'h00; bad[1] = 8'h05;
    for (int i = 0; i < 2; i++) begin
      send_byte(8'hA5);
      send_byte(bad[i]);
      @(negedge clk);
      checks++;
      if ({err, busy} !== 2'b10) begin
        errors++;
        $display("FAIL bad_index_err: index %h got err/busy=%b, expected 10", bad[i], {err, busy});
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL bad_index_pulse: index %h got err=%b a cycle later, expected 0", bad[i], err);
      end
    end
    checks++;
    if (n_writes - w0 !== 0) begin
      errors++;
      $display("FAIL bad_index_writes: got %0d, expected 0", n_writes - w0);
    end
    send_packet(8'h04, 2, 1024);
    drain_and_check("idx4", w0, d0, 1024, 1);
  endtask

  task automatic test_gaps();
    int w0 = n_writes;
    int d0 = n_done;
    gap_pct = 50;
    send_packet(8'h03, 0, 1024);
    gap_pct = 0;
    drain_and_check("gaps", w0, d0, 1024, 1);
  endtask

  task automatic test_reset_mid();
    int w0;
    int d0;
    send_packet(8'h02, 1, 100);
    send_byte(8'h07);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, wr_en, busy, done, err} !== 5'b10000) begin
      errors++;
      $display("FAIL midreset_flags: got ready/wr_en/busy/done/err=%b, expected 10000",
               {in_ready, wr_en, busy, done, err});
    end
    checks++;
    if ({wr_index, wr_row, wr_col, wr_data} !== 35'd0) begin
      errors++;
      $display("FAIL midreset_fields: got idx=%0d row=%0d col=%0d data=%h, expected all 0",
               wr_index, wr_row, wr_col, wr_data);
    end
    @(negedge clk);
    reset = 1'b0;
    w0 = n_writes;
    d0 = n_done;
    send_packet(8'h02, 1, 1024);
    drain_and_check("after_reset", w0, d0, 1024, 1);
  endtask

  task automatic test_hdr_as_data();
    int w0 = n_writes;
    int d0 = n_done;
    send_packet(8'h01, 3, 1024);
    drain_and_check("hdr_data", w0, d0, 1024, 1);
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_garbage();
    test_bad_index();
    test_gaps();
    test_reset_mid();
    test_hdr_as_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
